ifu_prefetch: RTL and testbench
===============================

# ifu_prefetch

Parametrised instruction-fetch unit with a decoupling prefetch queue. It generates sequential fetch addresses starting from a reset vector and issues them on a valid/ready instruction-memory request channel. Responses are buffered in a DEPTH-entry in-order queue and delivered to decode with their PC and the previous delivered PC. A redirect from execute flushes the queue and discards stale in-flight responses.

## Interface
- XLEN, 32: PC/address width.
- RESET_PC, 0: first fetch address after reset; XLEN bits.
- DEPTH, 4: queue entries; power of two, ≥2.
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] are ignored and treated as 0.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address.
- imem_rsp_valid  in  1  response valid. Responses are in order and cannot be back-pressured.
- imem_rsp_data  in  32  instruction word.
- fetch_valid  out  1  head instruction available.
- fetch_ready  in  1  decode accepts it.
- fetch_pc  out  XLEN  PC of head instruction.
- fetch_instr  out  32  head instruction.
- fetch_prev_pc  out  XLEN  PC of the last instruction delivered.

## Operation
- Reset (i_rst=1 at an edge):
  - next_pc=RESET_PC; queue empty; alloc_cnt=0; drop_cnt=0; fetch_prev_pc=0.
  - Outputs during and after reset: fetch_valid=0, imem_req_valid=0 while i_rst=1.
- Issue:
  - imem_req_valid = !i_rst && !redirect_valid && (alloc_cnt + drop_cnt < DEPTH).
  - imem_req_addr = next_pc.
  - On accept (valid && ready): allocate the tail entry {pc=next_pc, filled=0}; next_pc += 4 (wraps mod 2^XLEN); alloc_cnt++.
- Response:
  - If drop_cnt>0: discard the response, drop_cnt--.
  - Otherwise: write data into the oldest unfilled entry and set filled=1.
- Delivery:
  - fetch_valid = head entry allocated && filled && !redirect_valid.
  - On handshake: pop the head; alloc_cnt--; fetch_prev_pc <= fetch_pc.
- Redirect, which has priority over all other events in the same cycle:
  - Free all entries; alloc_cnt=0; next_pc=redirect_pc.
  - drop_cnt <= drop_cnt + (allocated-unfilled entries) − (1 if imem_rsp_valid this cycle).
  - A response arriving in the redirect cycle is consumed as a drop, never written.
  - No request is issued and no delivery occurs in the redirect cycle.
  - fetch_prev_pc is unchanged.
- Simultaneous response, request accept and pop in one cycle: all three apply; alloc_cnt changes by (+accept − pop).
- Full (alloc_cnt + drop_cnt == DEPTH): imem_req_valid=0. This bounds memory outstanding requests to DEPTH.
- Empty: fetch_valid=0, and fetch_pc/fetch_instr are don't-care.
- A response with no outstanding request is illegal; it is an assertion, and behaviour is undefined.

## Timing
- First request: cycle after i_rst deasserts, addr=RESET_PC.
- Request to delivery: a response in cycle t gives fetch_valid at the earliest in t+1. There is no combinational rsp→fetch path.
- Back-to-back: with zero-wait memory (ready=1, response the following cycle), one instruction is delivered per cycle in steady state.
- Redirect in cycle t: the request for redirect_pc is issued in t+1, provided drop_cnt < DEPTH.
- imem_req_addr is stable while imem_req_valid && !imem_req_ready.
- The fetch outputs are stable while fetch_valid && !fetch_ready, unless redirect_valid.
- Reset asserted mid-operation discards everything in one cycle. Responses arriving after the reset cycle are counted as illegal; memory must be reset together with this block.

## Structure
- Package ifu_pkg:
  - INSTR_W=32 and PC_STEP=4.
  - Typedef fetch_entry_t {pc, instr, filled}.
  - Function clog2-based count widths (counters are $clog2(DEPTH+1) bits).
- Sub-module ifu_fetch_queue: DEPTH-entry circular buffer.
  - Pointers: head, fill and tail, each $clog2(DEPTH) bits and wrapping.
  - Ports: alloc, fill, pop and flush.
- Top level: next_pc register, drop counter, issue logic and prev_pc register.

## Test plan
- Reset, ready=1, 1-cycle responses with data=addr^32'hFFFF_0000 → requests 0,4,8,…; fetch_pc=0,4,8 each with matching instr; fetch_prev_pc trails by one delivery.
- fetch_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; on release, deliveries 0,4,8,C in order.
- Redirect to 0x100 with 3 requests outstanding, one response in the same cycle → the next 2 responses are dropped; the first delivered fetch_pc=0x100.
- imem_req_ready low for 5 cycles → imem_req_addr held constant; no duplicate allocation.
- RESET_PC=32'hFFFF_FFF8 → fetch PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- Reset asserted mid-stream with a full queue → the next cycle fetch_valid=0, imem_req_valid=0, fetch_prev_pc=0; the first request after release is at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and sizing helpers for the instruction-fetch unit.
package ifu_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned MAX_XLEN = 64;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [INSTR_W-1:0]  instr;
    logic                filled;
  } fetch_entry_t;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// In-order prefetch queue: entries are allocated at request time and filled
// later by responses, so head/fill/tail pointers advance independently.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      alloc_i,
  input  logic [XLEN-1:0]           alloc_pc_i,
  input  logic                      fill_i,
  input  logic [INSTR_W-1:0]        fill_data_i,
  input  logic                      pop_i,
  output logic                      head_valid_o,
  output logic [XLEN-1:0]           head_pc_o,
  output logic [INSTR_W-1:0]        head_instr_o,
  output logic [cnt_w(DEPTH)-1:0]   alloc_cnt_o,
  output logic [cnt_w(DEPTH)-1:0]   unfilled_cnt_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CW-1:0] alloc_cnt_q, alloc_cnt_d, filled_cnt_q, filled_cnt_d;
  logic          unused_pc_hi;

  always_comb begin
    head_d       = head_q;
    fill_d       = fill_q;
    tail_d       = tail_q;
    alloc_cnt_d  = alloc_cnt_q;
    filled_cnt_d = filled_cnt_q;
    if (flush_i) begin
      head_d       = '0;
      fill_d       = '0;
      tail_d       = '0;
      alloc_cnt_d  = '0;
      filled_cnt_d = '0;
    end else begin
      if (alloc_i) tail_d = tail_q + PW'(1);
      if (fill_i)  fill_d = fill_q + PW'(1);
      if (pop_i)   head_d = head_q + PW'(1);
      alloc_cnt_d  = alloc_cnt_q + CW'(alloc_i) - CW'(pop_i);
      filled_cnt_d = filled_cnt_q + CW'(fill_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q       <= '0;
      fill_q       <= '0;
      tail_q       <= '0;
      alloc_cnt_q  <= '0;
      filled_cnt_q <= '0;
    end else begin
      head_q       <= head_d;
      fill_q       <= fill_d;
      tail_q       <= tail_d;
      alloc_cnt_q  <= alloc_cnt_d;
      filled_cnt_q <= filled_cnt_d;
    end
  end

  // Storage needs no reset: alloc_cnt gates every read and alloc clears filled.
  always_ff @(posedge clk_i) begin
    if (alloc_i && !flush_i) begin
      mem_q[tail_q].pc     <= MAX_XLEN'(alloc_pc_i);
      mem_q[tail_q].filled <= 1'b0;
    end
    if (fill_i && !flush_i) begin
      mem_q[fill_q].instr  <= fill_data_i;
      mem_q[fill_q].filled <= 1'b1;
    end
  end

  assign head_valid_o   = (alloc_cnt_q != '0) && mem_q[head_q].filled;
  assign head_pc_o      = mem_q[head_q].pc[XLEN-1:0];
  assign head_instr_o   = mem_q[head_q].instr;
  assign alloc_cnt_o    = alloc_cnt_q;
  assign unfilled_cnt_o = alloc_cnt_q - filled_cnt_q;
  assign unused_pc_hi   = ^mem_q[head_q].pc;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: sequential PC generation, bounded request issue,
// drop accounting for stale responses after redirect, and prev-PC tracking.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [XLEN-1:0]    fetch_pc,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic [XLEN-1:0]    fetch_prev_pc
);

  localparam int unsigned  CW      = cnt_w(DEPTH);
  localparam logic [CW:0]  DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] next_pc_q, next_pc_d, prev_pc_q, prev_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d, alloc_cnt, unfilled_cnt;
  logic [CW:0]     inflight, outstanding;
  logic            head_valid, req_fire, rsp_fill, pop;
  logic            unused_redirect_lo;

  // Valid/ready: a transfer happens on a rising edge where both are high;
  // a valid source holds its payload stable until that edge.
  assign inflight       = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};
  assign imem_req_valid = !i_rst && !redirect_valid && (inflight < DEPTH_C);
  assign imem_req_addr  = next_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fill       = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign fetch_valid    = !i_rst && !redirect_valid && head_valid;
  assign pop            = fetch_valid && fetch_ready;
  assign fetch_prev_pc  = prev_pc_q;

  always_comb begin
    next_pc_d  = next_pc_q;
    drop_cnt_d = drop_cnt_q;
    prev_pc_d  = prev_pc_q;
    if (redirect_valid) begin
      // Every unfilled entry still has a response on its way back.
      next_pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt_d = drop_cnt_q + unfilled_cnt - CW'(imem_rsp_valid);
    end else begin
      if (req_fire)                            next_pc_d  = next_pc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid && drop_cnt_q != '0)  drop_cnt_d = drop_cnt_q - CW'(1);
      if (pop)                                 prev_pc_d  = fetch_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      next_pc_q  <= RESET_PC;
      drop_cnt_q <= '0;
      prev_pc_q  <= '0;
    end else begin
      next_pc_q  <= next_pc_d;
      drop_cnt_q <= drop_cnt_d;
      prev_pc_q  <= prev_pc_d;
    end
  end

  ifu_fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i          (i_clk),
    .rst_i          (i_rst),
    .flush_i        (redirect_valid),
    .alloc_i        (req_fire),
    .alloc_pc_i     (next_pc_q),
    .fill_i         (rsp_fill),
    .fill_data_i    (imem_rsp_data),
    .pop_i          (pop),
    .head_valid_o   (head_valid),
    .head_pc_o      (fetch_pc),
    .head_instr_o   (fetch_instr),
    .alloc_cnt_o    (alloc_cnt),
    .unfilled_cnt_o (unfilled_cnt)
  );

  assign unused_redirect_lo = ^redirect_pc[1:0];
  assign outstanding        = {1'b0, unfilled_cnt} + {1'b0, drop_cnt_q};

  a_rsp_expected: assert property (@(posedge i_clk) disable iff (i_rst)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed scenarios plus a randomized run, checked
// against an epoch-based model of which fetched PCs must reach decode.
module tb_ifu_prefetch;

  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] MASK    = 32'hFFFF_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, redirect_valid = 1'b0, req_ready = 1'b0;
  logic        rsp_valid = 1'b0, fetch_ready = 1'b0;
  logic [31:0] redirect_pc = '0, rsp_data = '0;
  logic        req_valid, fetch_valid;
  logic [31:0] req_addr, fetch_pc, fetch_instr, fetch_prev_pc;

  logic        w_rst = 1'b1, w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_req_valid, w_fetch_valid;
  logic [31:0] w_req_addr, w_fetch_pc, w_fetch_instr, w_fetch_prev_pc;

  ifu_prefetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .fetch_prev_pc(fetch_prev_pc)
  );

  ifu_prefetch #(.XLEN(32), .RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_w (
    .i_clk(clk), .i_rst(w_rst),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .fetch_valid(w_fetch_valid), .fetch_ready(1'b1),
    .fetch_pc(w_fetch_pc), .fetch_instr(w_fetch_instr), .fetch_prev_pc(w_fetch_prev_pc)
  );

  int vectors = 0, miscompares = 0;
  int rsp_mode = 1;       // 0: memory silent, 1: answer every cycle, 2: random
  int stale = 0;          // responses still owed for requests from a dead epoch
  logic [31:0] exp_q[$];  // live-epoch PCs accepted and not yet delivered
  logic [31:0] mem_q[$];  // addresses the memory still owes a response for
  logic [31:0] exp_req_addr = '0, exp_prev = '0;

  logic        s_req_valid, s_fetch_valid, s_acc, s_del;
  logic [31:0] s_req_addr, s_fetch_pc, s_fetch_instr, s_prev;

  // One clock: memory response, sample before the edge, check, update model.
  task automatic cycle();
    logic exp_rv;
    exp_rv = !rst && !redirect_valid && ((exp_q.size() + stale) < DEPTH);
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (!rst && mem_q.size() != 0 &&
        (rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(0, 99) < 60))) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_q.pop_front() ^ MASK;
      if (stale > 0 && !redirect_valid) stale--;
    end
    #1;
    s_req_valid = req_valid;  s_req_addr = req_addr;
    s_fetch_valid = fetch_valid; s_fetch_pc = fetch_pc;
    s_fetch_instr = fetch_instr; s_prev = fetch_prev_pc;
    s_acc = req_valid && req_ready;
    s_del = fetch_valid && fetch_ready;

    vectors++;
    if (req_valid !== exp_rv) begin
      miscompares++;
      $display("FAIL req_valid: got %b want %b (live=%0d stale=%0d)", req_valid, exp_rv, exp_q.size(), stale);
    end
    if (rst || redirect_valid) begin
      vectors++;
      if (fetch_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_quiet: fetch_valid=%b want 0 during rst/redirect", fetch_valid);
      end
    end
    if (req_valid === 1'b1) begin
      vectors++;
      if (req_addr !== exp_req_addr) begin
        miscompares++;
        $display("FAIL req_addr: got %h want %h", req_addr, exp_req_addr);
      end
    end
    if (fetch_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL fetch_spurious: fetch_valid with pc %h but nothing expected", fetch_pc);
      end else if (fetch_pc !== exp_q[0] || fetch_instr !== (exp_q[0] ^ MASK) ||
                   fetch_prev_pc !== exp_prev) begin
        miscompares++;
        $display("FAIL fetch_head: got pc=%h instr=%h prev=%h want pc=%h instr=%h prev=%h",
                 fetch_pc, fetch_instr, fetch_prev_pc, exp_q[0], exp_q[0] ^ MASK, exp_prev);
      end
    end

    if (rst) begin
      exp_q.delete(); mem_q.delete();
      stale = 0; exp_req_addr = 32'h0; exp_prev = 32'h0;
    end else if (redirect_valid) begin
      exp_q.delete();
      stale = mem_q.size();
      exp_req_addr = {redirect_pc[31:2], 2'b00};
    end else begin
      if (s_acc) begin
        exp_q.push_back(req_addr);
        mem_q.push_back(req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        vectors++;
        if (mem_q.size() > DEPTH) begin
          miscompares++;
          $display("FAIL outstanding: got %0d requests owed, limit %0d", mem_q.size(), DEPTH);
        end
      end
      if (s_del && exp_q.size() != 0) exp_prev = exp_q.pop_front();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; req_ready = 1'b1; fetch_ready = 1'b1; rsp_mode = 1;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    vectors++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_first_req: got valid=%b addr=%h want 1/00000000", s_req_valid, s_req_addr);
    end
    vectors++;
    if (s_fetch_valid !== 1'b0 || s_prev !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_fetch: got valid=%b prev=%h want 0/00000000", s_fetch_valid, s_prev);
    end
  endtask

  task automatic test_back_to_back();
    int del_cnt;
    del_cnt = 0;
    req_ready = 1'b1; fetch_ready = 1'b1; rsp_mode = 1;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (c >= 10 && s_del) begin
        del_cnt++;
        vectors++;
        if (s_fetch_pc !== s_prev + 32'd4) begin
          miscompares++;
          $display("FAIL prev_trail: pc=%h prev=%h want prev=pc-4", s_fetch_pc, s_prev);
        end
      end
    end
    vectors++;
    if (del_cnt != 20) begin
      miscompares++;
      $display("FAIL stream_rate: got %0d deliveries in 20 cycles want 20", del_cnt);
    end
  endtask

  task automatic test_decode_stall();
    int acc_cnt;
    logic [31:0] got[$];
    acc_cnt = 0;
    rst = 1'b1; cycle(); rst = 1'b0;
    fetch_ready = 1'b0; req_ready = 1'b1; rsp_mode = 1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (s_acc) acc_cnt++;
    end
    vectors++;
    if (acc_cnt != 4 || s_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_stop: got %0d accepts, last req_valid=%b want 4/0", acc_cnt, s_req_valid);
    end
    fetch_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (s_del) got.push_back(s_fetch_pc);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got.size() <= i || got[i] !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL stall_order[%0d]: got %h want %h", i, (got.size() > i) ? got[i] : 32'hx, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    bit seen;
    rst = 1'b1; cycle(); rst = 1'b0;
    fetch_ready = 1'b0; req_ready = 1'b1; rsp_mode = 0;
    repeat (3) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; rsp_mode = 1;
    cycle();
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    cycle();
    vectors++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL redirect_req: got valid=%b addr=%h want 1/00000100", s_req_valid, s_req_addr);
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle();
      if (s_fetch_valid) seen = 1'b1;
    end
    vectors++;
    if (!seen || s_fetch_pc !== 32'h100 || s_fetch_instr !== (32'h100 ^ MASK)) begin
      miscompares++;
      $display("FAIL redirect_first: seen=%b pc=%h instr=%h want pc=00000100 instr=%h",
               seen, s_fetch_pc, s_fetch_instr, 32'h100 ^ MASK);
    end
  endtask

  task automatic test_req_stall();
    logic [31:0] held;
    req_ready = 1'b1; fetch_ready = 1'b1; rsp_mode = 1;
    repeat (6) cycle();
    req_ready = 1'b0;
    cycle();
    held = s_req_addr;
    for (int c = 0; c < 4; c++) begin
      cycle();
      vectors++;
      if (s_req_valid !== 1'b1 || s_req_addr !== held) begin
        miscompares++;
        $display("FAIL req_hold: got valid=%b addr=%h want 1/%h", s_req_valid, s_req_addr, held);
      end
    end
    req_ready = 1'b1;
    cycle();
    cycle();
    vectors++;
    if (s_req_valid === 1'b1 && s_req_addr !== held + 32'd4) begin
      miscompares++;
      $display("FAIL req_release: got addr=%h want %h", s_req_addr, held + 32'd4);
    end
  endtask

  task automatic test_random();
    rsp_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      rst            = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = $urandom();
      req_ready      = ($urandom_range(0, 99) < 70);
      fetch_ready    = ($urandom_range(0, 99) < 70);
      cycle();
    end
    rst = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; cycle(); rst = 1'b0;
    req_ready = 1'b1; fetch_ready = 1'b1; rsp_mode = 1;
    repeat (8) cycle();
    fetch_ready = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    vectors++;
    if (s_fetch_valid !== 1'b0 || s_prev !== 32'h0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got fv=%b prev=%h rv=%b addr=%h want 0/00000000/1/00000000",
               s_fetch_valid, s_prev, s_req_valid, s_req_addr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wq[$];
    logic [31:0] got[$];
    logic [31:0] want [3];
    want = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    w_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    w_rst = 1'b0;
    for (int c = 0; c < 30 && got.size() < 3; c++) begin
      w_rsp_valid = 1'b0;
      if (wq.size() != 0) begin
        w_rsp_valid = 1'b1;
        w_rsp_data  = wq.pop_front() ^ MASK;
      end
      #1;
      if (w_fetch_valid) begin
        got.push_back(w_fetch_pc);
        vectors++;
        if (w_fetch_instr !== (w_fetch_pc ^ MASK)) begin
          miscompares++;
          $display("FAIL wrap_instr: got %h want %h", w_fetch_instr, w_fetch_pc ^ MASK);
        end
      end
      if (w_req_valid) wq.push_back(w_req_addr);
      @(posedge clk); @(negedge clk);
    end
    w_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got.size() <= i || got[i] !== want[i]) begin
        miscompares++;
        $display("FAIL wrap_pc[%0d]: got %h want %h", i, (got.size() > i) ? got[i] : 32'hx, want[i]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_decode_stall();
    test_redirect();
    test_req_stall();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
